// File: rtl/text_overlay_ctrl.sv
// text_overlay_ctrl: single-line text overlay sequencer.
// Keeps a double-buffered line of character codes, drives the glyph ROM
// address from the pixel coordinate and returns a lit/unlit pixel two
// cycles after the coordinate was presented.
module text_overlay_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CHARS      = 16,
    parameter int unsigned X0         = 64,
    parameter int unsigned Y0         = 32,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter logic [ADDR_WIDTH-1:0] BLANK_CODE = ADDR_WIDTH'(5'b11111)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_start,
    input  logic                       active,
    input  logic [9:0]                 hpos,
    input  logic [9:0]                 vpos,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(CHARS)-1:0]   wr_idx,
    input  logic [ADDR_WIDTH-1:0]      wr_char,
    input  logic                       commit,
    output logic                       commit_done,
    output logic [ADDR_WIDTH-1:0]      rom_char,
    output logic [2:0]                 rom_row,
    output logic [2:0]                 rom_col,
    input  logic                       rom_dot,
    output logic                       pixel_valid,
    output logic                       pixel_on
);

    localparam int unsigned IDX_W       = $clog2(CHARS);
    localparam int unsigned DOT_PX      = 1 << SCALE_LOG2;
    localparam int unsigned X_END       = X0 + CHARS * 8 * DOT_PX;
    localparam int unsigned Y_END       = Y0 + 8 * DOT_PX;
    // Glyph ROM rows at and above this code are not populated.
    localparam int unsigned FIRST_UNPOP = 30;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    wr_ready_q, wr_ready_d;
    logic                    commit_done_q, commit_done_d;
    logic                    swap_c;
    logic                    wr_fire_c;

    logic [ADDR_WIDTH-1:0]   shadow_q [CHARS];
    logic [ADDR_WIDTH-1:0]   front_q  [CHARS];

    logic [10:0]             hpos_x_c, vpos_x_c;
    logic [10:0]             dx_c, dy_c;
    logic                    inwin_c;
    logic [IDX_W-1:0]        idx_c;
    logic [2:0]              col_c, row_c;

    logic [IDX_W-1:0]        s1_idx_q;
    logic [2:0]              s1_col_q, s1_row_q;
    logic                    s1_inwin_q, s1_active_q;

    logic                    pixel_valid_q, pixel_on_q;

    assign wr_ready    = wr_ready_q;
    assign commit_done = commit_done_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_on    = pixel_on_q;
    assign wr_fire_c   = wr_valid && wr_ready_q;

    // Commit FSM next-state: arm on commit, swap buffers on the next frame_start.
    always_comb begin
        state_d       = state_q;
        swap_c        = 1'b0;
        commit_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    swap_c        = 1'b1;
                    commit_done_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
        endcase
        wr_ready_d = (state_d == ST_IDLE);
    end

    // Commit FSM state and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_ready_q    <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ready_q    <= wr_ready_d;
            commit_done_q <= commit_done_d;
        end
    end

    // Character buffers: host writes land in shadow, whole line copied to front on swap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHARS; i++) begin
                shadow_q[IDX_W'(i)] <= BLANK_CODE;
                front_q[IDX_W'(i)]  <= BLANK_CODE;
            end
        end else begin
            if (wr_fire_c) begin
                shadow_q[wr_idx] <= wr_char;
            end
            if (swap_c) begin
                for (int unsigned i = 0; i < CHARS; i++) begin
                    front_q[IDX_W'(i)] <= shadow_q[IDX_W'(i)];
                end
            end
        end
    end

    // Window test and glyph cell/dot coordinates for the incoming pixel.
    always_comb begin
        hpos_x_c = {1'b0, hpos};
        vpos_x_c = {1'b0, vpos};
        dx_c     = hpos_x_c - 11'(X0);
        dy_c     = vpos_x_c - 11'(Y0);
        inwin_c  = active
                   && (hpos_x_c >= 11'(X0)) && (hpos_x_c < 11'(X_END))
                   && (vpos_x_c >= 11'(Y0)) && (vpos_x_c < 11'(Y_END));
        idx_c    = IDX_W'(dx_c >> (3 + SCALE_LOG2));
        col_c    = 3'(dx_c >> SCALE_LOG2);
        row_c    = 3'(dy_c >> SCALE_LOG2);
    end

    // Stage 1: register coordinate decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_idx_q    <= '0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
            s1_inwin_q  <= 1'b0;
            s1_active_q <= 1'b0;
        end else begin
            s1_idx_q    <= idx_c;
            s1_col_q    <= col_c;
            s1_row_q    <= row_c;
            s1_inwin_q  <= inwin_c;
            s1_active_q <= active;
        end
    end

    // Glyph ROM address; outside the window point at the blank glyph.
    always_comb begin
        rom_char = BLANK_CODE;
        rom_row  = 3'd0;
        rom_col  = 3'd0;
        if (s1_inwin_q) begin
            rom_char = front_q[s1_idx_q];
            rom_row  = s1_row_q;
            rom_col  = s1_col_q;
        end
    end

    // Stage 2: register the returned dot, masking blank and unpopulated codes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_valid_q <= 1'b0;
            pixel_on_q    <= 1'b0;
        end else begin
            pixel_valid_q <= s1_active_q;
            pixel_on_q    <= s1_inwin_q
                             && (rom_char != BLANK_CODE)
                             && (32'(rom_char) < FIRST_UNPOP)
                             && rom_dot;
        end
    end

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Directed bench for text_overlay_ctrl with a behavioural glyph ROM and
// a scoreboard of expected pixel outputs.
module tb_text_overlay_ctrl;

    localparam int X0 = 64;
    localparam int Y0 = 32;
    localparam int SC = 2;
    localparam int NC = 16;

    typedef struct {
        logic valid;
        logic on;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       active;
    logic [9:0] hpos, vpos;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_idx;
    logic [4:0] wr_char;
    logic       commit;
    logic       commit_done;
    logic [4:0] rom_char;
    logic [2:0] rom_row, rom_col;
    logic       rom_dot;
    logic       pixel_valid, pixel_on;

    int         n_checks = 0;
    int         n_fail   = 0;

    exp_t       sb[$];
    logic [4:0] front_m  [NC];
    logic [4:0] shadow_m [NC];
    logic       pend_m;
    logic       rdy_m;
    logic [7:0] g_tb;
    logic [15:0] pat;

    always #5 clk = ~clk;

    text_overlay_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .active      (active),
        .hpos        (hpos),
        .vpos        (vpos),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_idx      (wr_idx),
        .wr_char     (wr_char),
        .commit      (commit),
        .commit_done (commit_done),
        .rom_char    (rom_char),
        .rom_row     (rom_row),
        .rom_col     (rom_col),
        .rom_dot     (rom_dot),
        .pixel_valid (pixel_valid),
        .pixel_on    (pixel_on)
    );

    // Glyph ROM model: bit [col] of the row word is the dot at that column.
    function automatic logic [7:0] glyph_row(input logic [4:0] code, input logic [2:0] row);
        case (code)
            5'd1:         glyph_row = (row == 3'd1) ? 8'h0C : 8'h08;
            5'd2:         glyph_row = 8'h3C;
            5'd7:         glyph_row = (row == 3'd0) ? 8'h3E : 8'h20;
            5'd30, 5'd31: glyph_row = 8'hFF;
            default:      glyph_row = 8'h81;
        endcase
    endfunction

    always_comb begin
        g_tb    = glyph_row(rom_char, rom_row);
        rom_dot = g_tb[rom_col];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model for this edge, queue the expected pixel, then compare.
    task automatic cyc(input bit chk_rom);
        logic       swap;
        logic       inwin;
        int         h, v, dx, idx;
        logic [2:0] er, ec;
        logic [4:0] ech;
        logic [7:0] g;
        exp_t       e;
        if (wr_valid && rdy_m) shadow_m[wr_idx] = wr_char;
        swap = pend_m && frame_start;
        if (swap) begin
            front_m = shadow_m;
            pend_m  = 1'b0;
        end else if (!pend_m && commit) begin
            pend_m = 1'b1;
        end
        h = int'(hpos);
        v = int'(vpos);
        inwin = active && (h >= X0) && (h < X0 + NC * 8 * SC) && (v >= Y0) && (v < Y0 + 8 * SC);
        ech = 5'd31;
        er  = 3'd0;
        ec  = 3'd0;
        if (inwin) begin
            dx  = h - X0;
            idx = dx / (8 * SC);
            ec  = 3'((dx / SC) % 8);
            er  = 3'(((v - Y0) / SC) % 8);
            ech = front_m[idx];
        end
        g       = glyph_row(ech, er);
        e.valid = active;
        e.on    = inwin && (ech < 5'd30) && g[ec];
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        rdy_m = !pend_m;
        check("wr_ready", 32'(wr_ready), 32'(rdy_m));
        check("commit_done", 32'(commit_done), 32'(swap));
        if (chk_rom) begin
            check("rom_char", 32'(rom_char), 32'(ech));
            check("rom_row", 32'(rom_row), 32'(er));
            check("rom_col", 32'(rom_col), 32'(ec));
        end
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            check("pixel_valid", 32'(pixel_valid), 32'(e.valid));
            check("pixel_on", 32'(pixel_on), 32'(e.on));
        end
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        rst_n  = 1'b0;
        active = 1'b1;
        hpos   = 10'd68;
        vpos   = 10'd34;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
            check("rst_pixel_on", 32'(pixel_on), 32'd0);
            check("rst_wr_ready", 32'(wr_ready), 32'd0);
            check("rst_commit_done", 32'(commit_done), 32'd0);
        end
        for (int i = 0; i < NC; i++) begin
            front_m[i]  = 5'd31;
            shadow_m[i] = 5'd31;
        end
        pend_m  = 1'b0;
        rdy_m   = 1'b0;
        sb.delete();
        e.valid = 1'b0;
        e.on    = 1'b0;
        sb.push_back(e);
        active  = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic px(input logic a, input int h, input int v);
        active = a;
        hpos   = 10'(h);
        vpos   = 10'(v);
        cyc(1'b1);
    endtask

    task automatic wr(input int idx, input int ch, input logic with_commit);
        wr_valid = 1'b1;
        wr_idx   = 4'(idx);
        wr_char  = 5'(ch);
        commit   = with_commit;
        cyc(1'b0);
        wr_valid = 1'b0;
        commit   = 1'b0;
    endtask

    task automatic ctl(input logic c, input logic fs);
        commit      = c;
        frame_start = fs;
        active      = 1'b0;
        cyc(1'b0);
        commit      = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_start = 1'b0;
        wr_valid    = 1'b0;
        wr_idx      = '0;
        wr_char     = '0;
        commit      = 1'b0;
        hpos        = '0;
        vpos        = '0;
        active      = 1'b0;
        pend_m      = 1'b0;
        rdy_m       = 1'b0;
        pat         = '0;

        // Reset behaviour and blank fill.
        do_reset(3);
        ctl(1'b0, 1'b0);
        for (int h = 64; h < 80; h++) px(1'b1, h, 32);
        px(1'b1, 68, 34);
        px(1'b0, 0, 0);

        // Write slots, commit (write+commit same cycle), swap four cycles later.
        wr(0, 1, 1'b0);
        wr(1, 30, 1'b0);
        wr(15, 7, 1'b1);
        wr(2, 2, 1'b0);
        ctl(1'b0, 1'b0);
        ctl(1'b0, 1'b0);
        ctl(1'b0, 1'b1);
        ctl(1'b0, 1'b0);

        // Render after swap.
        px(1'b1, 68, 34);
        px(1'b1, 64, 34);
        px(1'b1, 80, 32);
        px(1'b1, 82, 32);
        px(1'b0, 68, 34);

        // Shadow isolation: uncommitted write does not reach the front.
        wr(0, 2, 1'b0);
        ctl(1'b0, 1'b1);
        px(1'b1, 64, 32);
        px(1'b1, 68, 34);

        // Window edges.
        px(1'b1, 63, 32);
        px(1'b1, 320, 32);
        px(1'b1, 100, 31);
        px(1'b1, 100, 48);
        px(1'b1, 319, 32);
        px(1'b1, 64, 47);
        px(1'b0, 0, 0);

        // Commit and frame_start together in IDLE, extra commit while pending.
        ctl(1'b1, 1'b1);
        ctl(1'b0, 1'b0);
        ctl(1'b1, 1'b0);
        ctl(1'b0, 1'b1);
        ctl(1'b0, 1'b0);
        ctl(1'b0, 1'b1);
        px(1'b1, 64, 32);
        px(1'b1, 68, 32);

        // Latency and scaling on glyph '7' row 0.
        wr(0, 7, 1'b1);
        ctl(1'b0, 1'b1);
        ctl(1'b0, 1'b0);
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) px(1'b1, 64 + i, 32);
            else        px(1'b0, 0, 0);
            if (i >= 1) pat[16 - i] = pixel_on;
        end
        check("scale_pattern", 32'(pat), 32'h3FF0);
        px(1'b0, 0, 0);
        px(1'b1, 66, 32);
        px(1'b0, 0, 0);

        // Reset while a commit is pending discards it and the buffers.
        wr(0, 1, 1'b1);
        do_reset(2);
        ctl(1'b0, 1'b0);
        ctl(1'b0, 1'b1);
        ctl(1'b0, 1'b0);
        px(1'b1, 70, 32);
        px(1'b1, 68, 34);
        px(1'b0, 0, 0);
        px(1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_overlay_ctrl.md
Name: text_overlay_ctrl

Overview:
- Sequences the glyph bitmap ROM for a single-line text overlay on the video pixel stream.
- Holds a double-buffered line of character codes. The shadow copy is written by a host-side write port; the front copy is swapped in only at frame start.
- For each incoming pixel coordinate it drives ROM char/row/col combinationally, then registers the returned dot into a fixed-latency pixel output.
- Sits between the display timing generator and the pixel mixer.

Parameters:
ADDR_WIDTH, 5, width of the character code (matches glyph ROM).
CHARS, 16, characters per line; power of two, 2..64.
X0, 64, left pixel of text window.
Y0, 32, top pixel of text window.
SCALE_LOG2, 1, each glyph dot is rendered as 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels; range 0..2.
BLANK_CODE, 5'b11111, code rendered as all-off; used as the reset fill value.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
frame_start  in  1  one-cycle pulse at start of frame (before first active line)
active  in  1  display-active qualifier for hpos/vpos
hpos  in  10  current pixel x
vpos  in  10  current pixel y
wr_valid  in  1  shadow write request
wr_ready  out  1  shadow write accepted when high with wr_valid
wr_idx  in  $clog2(CHARS)  character slot
wr_char  in  ADDR_WIDTH  character code
commit  in  1  request shadow->front swap at next frame_start
commit_done  out  1  one-cycle pulse, cycle after swap
rom_char  out  ADDR_WIDTH  glyph ROM char
rom_row  out  3  glyph ROM row (0 = top)
rom_col  out  3  glyph ROM col (0 = leftmost)
rom_dot  in  1  glyph ROM dot (combinational from rom_*)
pixel_valid  out  1  active delayed 2 cycles
pixel_on  out  1  text pixel lit, qualified by pixel_valid

Behaviour:
- Reset (rst_n low at a clk edge): both buffers filled with BLANK_CODE. Pending flag cleared. wr_ready=0. commit_done=0, pixel_valid=0, pixel_on=0. Pipeline stage registers cleared. wr_ready=1 from the first cycle after reset release.
- Reset mid-frame or mid-commit discards pending commit and all buffer contents.
- Write port:
  - Write accepted when wr_valid && wr_ready; shadow[wr_idx] <= wr_char. Front buffer unaffected.
  - wr_ready = !pending.
- Commit state machine, states IDLE and PENDING:
  - IDLE -> PENDING when commit=1. A write accepted in the same cycle is applied first.
  - In PENDING, commit is ignored.
  - PENDING -> IDLE on frame_start: front <= shadow (all slots, one cycle). commit_done=1 on the next cycle.
  - commit and frame_start in the same IDLE cycle: enter PENDING, no swap this frame. Swap happens at the following frame_start.
  - frame_start in IDLE: no action.
- Pipeline stage 1 (registered from inputs, cycle n+1):
  - dx = hpos - X0 and dy = vpos - Y0, computed in 11 bits.
  - inwin = active && hpos >= X0 && hpos < X0 + CHARS*8<<SCALE_LOG2 && vpos >= Y0 && vpos < Y0 + 8<<SCALE_LOG2.
  - Register idx = dx >> (3+SCALE_LOG2), col = (dx >> SCALE_LOG2) & 7, row = (dy >> SCALE_LOG2) & 7, inwin, active.
- ROM drive (combinational from stage 1):
  - rom_char = front[idx], rom_row = row, rom_col = col.
  - When !inwin, drive rom_char = BLANK_CODE, row = 0, col = 0.
- Pipeline stage 2 (cycle n+2):
  - pixel_valid <= stage1 active.
  - pixel_on <= inwin && rom_char != BLANK_CODE && rom_dot.
- Codes >= 30 render as off regardless of rom_dot, because those ROM rows are unpopulated.
- Fixed latency: hpos/vpos/active at edge n -> pixel outputs valid after edge n+2. No stalls.
- A swap at frame_start takes effect for any coordinate sampled at the next edge or later. The front buffer never changes during active video, provided frame_start precedes the active region.

Test Plan:
- Reset: hold rst_n=0 3 cycles with active=1 -> pixel_valid=0, pixel_on=0, wr_ready=0, commit_done=0. After release, wr_ready=1; all text pixels off (BLANK fill).
- Write/commit/swap: write idx0=5'b00001 ('1'), commit, frame_start 4 cycles later -> commit_done pulses exactly 1 cycle after frame_start. wr_ready=0 between commit and the swap. Then hpos=68, vpos=34 (row1, col2, defaults) -> rom_char=1, rom_row=1, rom_col=2, pixel_on=1 two cycles later. hpos=64 (col0) -> pixel_on=0.
- Shadow isolation: after the swap, write idx0=5'b00010 without commit; run a frame -> rendered glyph remains '1'. rom_char=1 at hpos=64, vpos=32.
- Window edges (defaults, window x 64..319, y 32..47): hpos=63, hpos=320, vpos=31, vpos=48 -> pixel_on=0, rom_char=BLANK_CODE. hpos=319 -> idx=15, col=7.
- Simultaneous commit+frame_start in IDLE -> no commit_done that frame. commit_done occurs after the next frame_start. commit during PENDING -> no extra pulse.
- Latency/scale: stream hpos 64..79 on vpos=32 with active=1 and slot0='7' (row0=00111110) -> pixel_on pattern 0,0,1,1,1,1,1,1,1,1,1,1,0,0,0,0, starting exactly 2 cycles after the first hpos. pixel_valid tracks active with 2-cycle delay.
